cpu_controller: RTL and testbench

//  Sequencer for the VeriRisc CPU: 8-phase FSM, one instruction per 8 clocks.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/ctrl_output_decode.sv | 58 +++++
 rtl/cpu_controller.sv | 89 ++++++++
 tb/tb_cpu_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the VeriRisc CPU controller: opcodes, phase
// encoding and the strobe bundle passed from the decoder to the top.
package cpu_pkg;

   localparam int unsigned OPC_WIDTH   = 3;
   localparam int unsigned PHASE_WIDTH = 3;

   // Opcodes as held in IR[7:5]
   localparam logic [OPC_WIDTH-1:0] HLT = 3'd0;
   localparam logic [OPC_WIDTH-1:0] SKZ = 3'd1;
   localparam logic [OPC_WIDTH-1:0] ADD = 3'd2;
   localparam logic [OPC_WIDTH-1:0] AND = 3'd3;
   localparam logic [OPC_WIDTH-1:0] XOR = 3'd4;
   localparam logic [OPC_WIDTH-1:0] LDA = 3'd5;
   localparam logic [OPC_WIDTH-1:0] STO = 3'd6;
   localparam logic [OPC_WIDTH-1:0] JMP = 3'd7;

   // Eight sequencing phases, one instruction per full lap
   typedef enum logic [PHASE_WIDTH-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   // Control strobes produced for one phase
   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic ld_ac;
      logic inc_pc;
      logic ld_pc;
      logic wr;
      logic data_e;
      logic halt;
   } ctrl_strobes_t;

   // Opcodes that read memory into the accumulator
   function automatic logic is_aluop(input logic [OPC_WIDTH-1:0] opc);
      return (opc == ADD) || (opc == AND) || (opc == XOR) || (opc == LDA);
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational strobe table: (phase, opcode, zero) -> control strobes.
// Phases 0-3 are the instruction fetch and do not look at the opcode.
module ctrl_output_decode
   import cpu_pkg::*;
(
   input  phase_t                 phase,
   input  logic [OPC_WIDTH-1:0]   opcode,
   input  logic                   zero,
   output ctrl_strobes_t          strobes
);

   logic aluop;

   assign aluop = is_aluop(opcode);

   // Strobe table per phase; every strobe defaults low
   always_comb begin
      strobes = '0;
      unique case (phase)
         INST_ADDR: begin
            strobes.sel = 1'b1;
         end
         INST_FETCH: begin
            strobes.sel = 1'b1;
            strobes.rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            strobes.sel   = 1'b1;
            strobes.rd    = 1'b1;
            strobes.ld_ir = 1'b1;
         end
         OP_ADDR: begin
            strobes.inc_pc = 1'b1;
            strobes.halt   = (opcode == HLT);
         end
         OP_FETCH: begin
            strobes.rd = aluop;
         end
         ALU_OP: begin
            strobes.rd     = aluop;
            strobes.inc_pc = (opcode == SKZ) && zero;
            strobes.ld_pc  = (opcode == JMP);
            strobes.data_e = (opcode == STO);
         end
         STORE: begin
            strobes.rd     = aluop;
            strobes.ld_ac  = aluop;
            strobes.ld_pc  = (opcode == JMP);
            strobes.wr     = (opcode == STO);
            strobes.data_e = (opcode == STO);
         end
         default: begin
            strobes = '0;
         end
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// VeriRisc CPU sequencer: 8-phase counter plus strobe decode.
// Optional feature macro CTRL_HALT_LATCH_EN: HLT parks the sequencer in
// OP_ADDR until a resume pulse; otherwise halt is a one-cycle pulse.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [OPC_WIDTH-1:0]   opcode,
   input  logic                   zero,
`ifdef CTRL_HALT_LATCH_EN
   input  logic                   resume,
`endif
   output logic                   sel,
   output logic                   rd,
   output logic                   ld_ir,
   output logic                   ld_ac,
   output logic                   inc_pc,
   output logic                   ld_pc,
   output logic                   wr,
   output logic                   data_e,
   output logic                   halt,
   output logic [PHASE_WIDTH-1:0] phase
);

   phase_t        phase_q;
   ctrl_strobes_t dec_s;
   ctrl_strobes_t out_s;

   ctrl_output_decode u_decode (
      .phase   (phase_q),
      .opcode  (opcode),
      .zero    (zero),
      .strobes (dec_s)
   );

`ifdef CTRL_HALT_LATCH_EN
   logic halted_q;

   // Phase sequencer with sticky halt; entry cycle still issues inc_pc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else if (halted_q) begin
         if (resume) begin
            halted_q <= 1'b0;
            phase_q  <= OP_FETCH;
         end
      end else if ((phase_q == OP_ADDR) && (opcode == HLT)) begin
         halted_q <= 1'b1;
      end else begin
         phase_q <= phase_t'(phase_q + 3'd1);
      end
   end

   // While parked only halt is asserted
   always_comb begin
      out_s = dec_s;
      if (halted_q) begin
         out_s      = '0;
         out_s.halt = 1'b1;
      end
   end
`else
   // Free-running phase sequencer, wraps 7 -> 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= INST_ADDR;
      end else begin
         phase_q <= phase_t'(phase_q + 3'd1);
      end
   end

   assign out_s = dec_s;
`endif

   assign sel    = out_s.sel;
   assign rd     = out_s.rd;
   assign ld_ir  = out_s.ld_ir;
   assign ld_ac  = out_s.ld_ac;
   assign inc_pc = out_s.inc_pc;
   assign ld_pc  = out_s.ld_pc;
   assign wr     = out_s.wr;
   assign data_e = out_s.data_e;
   assign halt   = out_s.halt;
   assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: driver pushes expected strobes into a queue,
// monitor pops and compares every cycle. Honors CTRL_HALT_LATCH_EN.
module tb_cpu_controller;
   import cpu_pkg::*;

`ifdef CTRL_HALT_LATCH_EN
   localparam bit LATCH = 1'b1;
   logic resume;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt;
   logic [2:0] phase;

   logic [11:0] sbq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          m_phase = 0;
   bit          m_halted = 1'b0;
   logic [11:0] mon_exp, mon_act;

   cpu_controller dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
`ifdef CTRL_HALT_LATCH_EN
      .resume (resume),
`endif
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .ld_ac  (ld_ac),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt),
      .phase  (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: per-opcode bitmask of phases in which each strobe is high
   function automatic logic [11:0] model_out(input int ph, input logic [2:0] opc,
                                              input logic z, input bit hl);
      logic [7:0] m_sel, m_rd, m_ldir, m_ldac, m_inc, m_ldpc, m_wr, m_de, m_hlt;
      logic [2:0] p;
      bit alu;
      if (hl) return {3'd4, 8'b0, 1'b1};
      alu    = (opc == ADD) || (opc == AND) || (opc == XOR) || (opc == LDA);
      m_sel  = 8'b0000_1111;
      m_rd   = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'b0);
      m_ldir = 8'b0000_1100;
      m_ldac = alu ? 8'b1000_0000 : 8'b0;
      m_inc  = 8'b0001_0000 | ((opc == SKZ && z) ? 8'b0100_0000 : 8'b0);
      m_ldpc = (opc == JMP) ? 8'b1100_0000 : 8'b0;
      m_wr   = (opc == STO) ? 8'b1000_0000 : 8'b0;
      m_de   = (opc == STO) ? 8'b1100_0000 : 8'b0;
      m_hlt  = (opc == HLT) ? 8'b0001_0000 : 8'b0;
      p      = 3'(ph);
      return {p, m_sel[p], m_rd[p], m_ldir[p], m_ldac[p], m_inc[p],
              m_ldpc[p], m_wr[p], m_de[p], m_hlt[p]};
   endfunction

   // One cycle of stimulus: drive, record expectation, advance the model
   task automatic drive_cycle(input bit r, input logic [2:0] op, input bit z, input bit res);
      @(negedge clk);
      rst    = r;
      opcode = op;
      zero   = z;
`ifdef CTRL_HALT_LATCH_EN
      resume = res;
`endif
      if (r) begin
         m_phase  = 0;
         m_halted = 1'b0;
      end
      sbq.push_back(model_out(m_phase, op, z, m_halted));
      if (r) begin
         m_phase  = 0;
         m_halted = 1'b0;
      end else if (m_halted) begin
         if (LATCH && res) begin
            m_halted = 1'b0;
            m_phase  = 5;
         end
      end else if (LATCH && m_phase == 4 && op == HLT) begin
         m_halted = 1'b1;
      end else begin
         m_phase = (m_phase + 1) % 8;
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation
   always @(negedge clk) begin
      #2;
      if (sbq.size() > 0) begin
         mon_exp = sbq.pop_front();
         mon_act = {phase, sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt};
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL strobes t=%0t got {phase,sel,rd,ld_ir,ld_ac,inc_pc,ld_pc,wr,data_e,halt}=%b want %b",
                     $time, mon_act, mon_exp);
         end
      end
   end

   initial begin
      logic [2:0] r_op;
      rst    = 1'b1;
      opcode = HLT;
      zero   = 1'b0;
`ifdef CTRL_HALT_LATCH_EN
      resume = 1'b0;
`endif
      // Reset state
      repeat (2) drive_cycle(1'b1, ADD, 1'b0, 1'b0);
      // ALU op free run
      repeat (16) drive_cycle(1'b0, ADD, 1'b0, 1'b0);
      // SKZ taken / not taken
      repeat (8) drive_cycle(1'b0, SKZ, 1'b1, 1'b0);
      repeat (8) drive_cycle(1'b0, SKZ, 1'b0, 1'b0);
      // JMP and STO full laps
      repeat (8) drive_cycle(1'b0, JMP, 1'b0, 1'b0);
      repeat (8) drive_cycle(1'b0, STO, 1'b1, 1'b0);
      // Reset in the middle of a STO at phase 6
      for (int i = 0; i < 16 && m_phase != 6; i++) drive_cycle(1'b0, STO, 1'b0, 1'b0);
      drive_cycle(1'b1, STO, 1'b0, 1'b0);
      repeat (4) drive_cycle(1'b0, STO, 1'b0, 1'b0);
      // HLT: long hold with resume low, then a resume pulse
      for (int i = 0; i < 16 && m_phase != 0; i++) drive_cycle(1'b0, LDA, 1'b0, 1'b0);
      repeat (16) drive_cycle(1'b0, HLT, 1'b0, 1'b0);
      drive_cycle(1'b0, HLT, 1'b0, 1'b1);
      repeat (6) drive_cycle(1'b0, HLT, 1'b0, 1'b0);
      // Randomized run; opcode changes only at instruction boundaries
      r_op = ADD;
      for (int i = 0; i < 2000; i++) begin
         if (m_phase == 0 && $urandom_range(0, 1) == 1) r_op = 3'($urandom_range(0, 7));
         drive_cycle($urandom_range(0, 63) == 0, r_op, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0);
      end
      repeat (2) @(negedge clk);
      #3;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending want 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
